// File: rtl/bus_arbiter.sv
// Shared memory bus arbiter between the CPU data path and the DMA controller.
// Grants DMA only at CPU transaction boundaries and inserts one turnaround cycle on release.
module bus_arbiter #(
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             BR,
  input  logic             dma_use_bus,
  input  logic             cpu_bus_req,
  input  logic             cpu_bus_busy,
  output logic             BG,
  output logic             cpu_stall,
  output logic [CNT_W-1:0] grant_count,
  output logic [CNT_W-1:0] busy_cycles,
  output logic             hold_timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 2);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CPU,
    GRANT,
    RELEASE
  } state_t;

  state_t state, next_state;
  logic [HOLD_W-1:0] hold_cnt;

  // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (BR) next_state = cpu_bus_busy ? WAIT_CPU : GRANT;
      WAIT_CPU: begin
        if (!BR)                next_state = IDLE;
        else if (!cpu_bus_busy) next_state = GRANT;
      end
      GRANT:    if (!BR) next_state = RELEASE;
      RELEASE:  next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // DMA wins ties: a pending BR in IDLE already blocks the CPU from starting an access.
  assign cpu_stall = cpu_bus_req && ((state != IDLE) || BR);

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      BG           <= 1'b0;
      grant_count  <= '0;
      busy_cycles  <= '0;
      hold_timeout <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      state <= next_state;
      BG    <= (next_state == GRANT);

      if ((state == GRANT) && !BR && (grant_count != '1))
        grant_count <= grant_count + 1'b1;

      if (BG && dma_use_bus && (busy_cycles != '1))
        busy_cycles <= busy_cycles + 1'b1;

      if ((next_state == GRANT) && (state != GRANT)) begin
        hold_cnt <= '0;
      end else if ((state == GRANT) && (hold_cnt != HOLD_LIMIT)) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LIMIT - 1'b1)
          hold_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (MAX_HOLD=8, CNT_W=4).
// Inputs change 1 time unit after posedge; outputs are checked before the next edge.
module tb_bus_arbiter;

  logic       Clk = 1'b0;
  logic       Reset, BR, dma_use_bus, cpu_bus_req, cpu_bus_busy;
  logic       BG, cpu_stall, hold_timeout;
  logic [3:0] grant_count, busy_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  bus_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .BR           (BR),
    .dma_use_bus  (dma_use_bus),
    .cpu_bus_req  (cpu_bus_req),
    .cpu_bus_busy (cpu_bus_busy),
    .BG           (BG),
    .cpu_stall    (cpu_stall),
    .grant_count  (grant_count),
    .busy_cycles  (busy_cycles),
    .hold_timeout (hold_timeout)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    Reset = 1'b1; BR = 1'b0; dma_use_bus = 1'b0; cpu_bus_req = 1'b0; cpu_bus_busy = 1'b0;
    tick();
    tick();
    check("rst_bg",      32'(BG), 0);
    check("rst_grants",  32'(grant_count), 0);
    check("rst_busy",    32'(busy_cycles), 0);
    check("rst_timeout", 32'(hold_timeout), 0);
    cpu_bus_req = 1'b1;
    #1;
    check("rst_stall_br0", 32'(cpu_stall), 0);
    cpu_bus_req = 1'b0;
    Reset = 1'b0;

    // Basic grant: 12 BG-high cycles with dma_use_bus tied high.
    dma_use_bus = 1'b1;
    BR = 1'b1;
    tick();
    check("basic_bg_rise", 32'(BG), 1);
    repeat (11) tick();
    check("basic_bg_held", 32'(BG), 1);
    BR = 1'b0;
    tick();
    check("basic_bg_fall",  32'(BG), 0);
    check("basic_grants",   32'(grant_count), 1);
    check("basic_busy",     32'(busy_cycles), 12);
    check("basic_timeout",  32'(hold_timeout), 1);
    dma_use_bus = 1'b0;
    tick();
    do_reset();

    // CPU busy deferral.
    cpu_bus_req = 1'b1; cpu_bus_busy = 1'b1; BR = 1'b1;
    #1;
    check("defer_stall_idle", 32'(cpu_stall), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("defer_bg_%0d", i), 32'(BG), 0);
      check($sformatf("defer_stall_%0d", i), 32'(cpu_stall), 1);
    end
    cpu_bus_busy = 1'b0;
    #1;
    check("defer_stall_wait", 32'(cpu_stall), 1);
    tick();
    check("defer_bg_rise", 32'(BG), 1);
    check("defer_stall_grant", 32'(cpu_stall), 1);
    BR = 1'b0;
    tick();
    check("defer_bg_fall", 32'(BG), 0);
    check("defer_stall_release", 32'(cpu_stall), 1);
    check("defer_grants", 32'(grant_count), 1);
    tick();
    check("defer_stall_idle_br0", 32'(cpu_stall), 0);
    check("defer_busy_unused", 32'(busy_cycles), 0);

    // Simultaneous request in IDLE: DMA wins.
    cpu_bus_req = 1'b0;
    tick();
    BR = 1'b1; cpu_bus_req = 1'b1;
    #1;
    check("simul_stall", 32'(cpu_stall), 1);
    tick();
    check("simul_bg", 32'(BG), 1);

    // Abandoned request from WAIT_CPU.
    BR = 1'b0;
    tick();
    tick();
    check("abandon_pre_grants", 32'(grant_count), 2);
    cpu_bus_busy = 1'b1; BR = 1'b1;
    tick();
    tick();
    check("abandon_wait_bg", 32'(BG), 0);
    BR = 1'b0;
    tick();
    check("abandon_bg", 32'(BG), 0);
    check("abandon_idle_stall", 32'(cpu_stall), 0);
    check("abandon_grants", 32'(grant_count), 2);

    // Back-to-back: BR re-raised during RELEASE.
    cpu_bus_busy = 1'b0; BR = 1'b1;
    tick();
    check("b2b_bg_first", 32'(BG), 1);
    tick();
    BR = 1'b0;
    tick();
    check("b2b_bg_fall", 32'(BG), 0);
    BR = 1'b1;
    tick();
    check("b2b_bg_turnaround", 32'(BG), 0);
    tick();
    check("b2b_bg_rerise", 32'(BG), 1);
    check("b2b_grants", 32'(grant_count), 3);
    BR = 1'b0; cpu_bus_req = 1'b0;
    tick();
    tick();
    do_reset();

    // Watchdog: 20 BG cycles with MAX_HOLD=8; busy_cycles saturates at 15.
    dma_use_bus = 1'b1; BR = 1'b1;
    tick();
    check("wd_bg_rise", 32'(BG), 1);
    repeat (8) tick();
    check("wd_timeout_at_8", 32'(hold_timeout), 0);
    tick();
    check("wd_timeout_at_9", 32'(hold_timeout), 1);
    check("wd_bg_kept", 32'(BG), 1);
    repeat (10) tick();
    check("wd_bg_kept_19", 32'(BG), 1);
    BR = 1'b0;
    tick();
    check("wd_bg_fall",  32'(BG), 0);
    check("wd_busy_sat", 32'(busy_cycles), 15);
    check("wd_grants",   32'(grant_count), 1);
    dma_use_bus = 1'b0;
    repeat (3) tick();
    check("wd_timeout_sticky", 32'(hold_timeout), 1);
    do_reset();
    check("wd_timeout_cleared", 32'(hold_timeout), 0);

    // Reset asserted mid-grant.
    BR = 1'b1; dma_use_bus = 1'b1;
    tick();
    tick();
    check("midrst_bg_before", 32'(BG), 1);
    Reset = 1'b1;
    tick();
    check("midrst_bg",     32'(BG), 0);
    check("midrst_grants", 32'(grant_count), 0);
    check("midrst_busy",   32'(busy_cycles), 0);
    BR = 1'b0; dma_use_bus = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    check("midrst_grants_after", 32'(grant_count), 0);

    // Saturation: 20 grants into a 4-bit counter.
    for (int g = 1; g <= 20; g++) begin
      BR = 1'b1;
      tick();
      BR = 1'b0;
      tick();
      tick();
      if (g == 14) check("sat_grants_14", 32'(grant_count), 14);
      if (g == 15) check("sat_grants_15", 32'(grant_count), 15);
    end
    check("sat_grants_20", 32'(grant_count), 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
